subtractor: RTL and testbench

- Decrementing counter: the down-direction counterpart of the team's incrementing counter.
- Loads a start value, decrements on `dec` strobes, and reports zero, expiry and underflow.
- Used as a credit or countdown tracker wherever an up-counter produces values that must be consumed.
- Single clock domain; registered outputs.

---
 rtl/subtractor_pkg.sv | 40 ++++
 rtl/subtractor.sv | 86 ++++++++
 tb/tb_subtractor.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/subtractor_pkg.sv
// subtractor_pkg: state encoding, decrement result type and next-value helper.
// Purely combinational helpers; no latency.
// No flow control lives here.
package subtractor_pkg;

    // Widest counter the helper function supports; callers zero-extend into it.
    localparam int SUB_MAX_W = 64;

    // State encoding constants.
    localparam logic [1:0] STATE_IDLE_ENC    = 2'd0;
    localparam logic [1:0] STATE_ARMED_ENC   = 2'd1;
    localparam logic [1:0] STATE_EXPIRED_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = STATE_IDLE_ENC,
        ST_ARMED   = STATE_ARMED_ENC,
        ST_EXPIRED = STATE_EXPIRED_ENC
    } state_t;

    typedef struct packed {
        logic [SUB_MAX_W-1:0] value;
        logic                 underflow;
    } dec_result_t;

    // One decrement step. At zero the result either wraps to all-ones (the
    // caller truncates to its own width) or sticks at zero.
    function automatic dec_result_t next_value(input logic [SUB_MAX_W-1:0] value,
                                               input logic                 wrap_en);
        dec_result_t res;
        if (value == '0) begin
            res.underflow = 1'b1;
            res.value     = wrap_en ? '1 : '0;
        end else begin
            res.underflow = 1'b0;
            res.value     = value - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/subtractor.sv
// subtractor: loadable down-counter with zero/expired/underflow reporting and IDLE/ARMED/EXPIRED FSM.
// Latency: load/dec/clr visible on out/state one cycle later; zero decoded from out with no extra delay.
// Backpressure: load_ready drops only while clr is high; SUBTRACTOR_SATURATE_EN makes dec at zero saturate instead of wrap.
module subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RST_VAL = 0
) (
    input  logic             aclk,
    input  logic             srst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             load_ready,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             expired,
    output logic             underflow,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] RST_OUT = WIDTH'(RST_VAL);

`ifdef SUBTRACTOR_SATURATE_EN
    localparam logic WRAP_EN = 1'b0;
`else
    localparam logic WRAP_EN = 1'b1;
`endif

    logic [WIDTH-1:0] r_out;
    state_t           r_state;
    logic             r_expired;
    logic             r_underflow;
    dec_result_t      w_nv;
    logic             w_load_acc;

    // Decrement candidate for the current value and load acceptance.
    always_comb begin
        w_nv       = next_value({{(SUB_MAX_W-WIDTH){1'b0}}, r_out}, WRAP_EN);
        w_load_acc = load & ~clr;
    end

    // Counter, FSM and single-cycle pulses; priority srst > clr > load > dec.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_out       <= RST_OUT;
            r_state     <= ST_IDLE;
            r_expired   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_expired   <= 1'b0;
            r_underflow <= 1'b0;
            if (clr) begin
                r_out   <= RST_OUT;
                r_state <= ST_IDLE;
            end else if (w_load_acc) begin
                // A dec arriving with an accepted load is dropped.
                r_out   <= load_val;
                r_state <= (load_val != '0) ? ST_ARMED : ST_EXPIRED;
            end else if (dec) begin
                r_out       <= w_nv.value[WIDTH-1:0];
                r_underflow <= w_nv.underflow;
                if (r_out == WIDTH'(1) && r_state == ST_ARMED) begin
                    r_expired <= 1'b1;
                    r_state   <= ST_EXPIRED;
                end
`ifndef SUBTRACTOR_SATURATE_EN
                // Wrapping back to a large count re-arms an expired counter.
                if (w_nv.underflow && r_state == ST_EXPIRED) begin
                    r_state <= ST_ARMED;
                end
`endif
            end
        end
    end

    assign load_ready = ~clr;
    assign out        = r_out;
    assign zero       = (r_out == '0);
    assign expired    = r_expired;
    assign underflow  = r_underflow;
    assign state      = r_state;

endmodule

// File: tb/tb_subtractor.sv
module tb_subtractor;

    localparam int W    = 8;
    localparam int RSTV = 0;
    localparam int MAXV = (1 << W) - 1;

    logic         aclk = 1'b0;
    logic         srst = 1'b1;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         load_ready;
    logic         dec = 1'b0;
    logic [W-1:0] out;
    logic         zero;
    logic         expired;
    logic         underflow;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int out;
        int st;
        bit zero;
        bit expd;
        bit und;
        bit lr;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: plain integer counter and state number.
    int m_out = RSTV;
    int m_st  = 0;

    subtractor #(.WIDTH(W), .RST_VAL(RSTV)) dut (
        .aclk      (aclk),
        .srst      (srst),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .load_ready(load_ready),
        .dec       (dec),
        .out       (out),
        .zero      (zero),
        .expired   (expired),
        .underflow (underflow),
        .state     (state)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // One stimulus cycle: drive inputs at negedge and push the expected result.
    task automatic cyc(input bit s, input bit c, input bit l, input int lv, input bit d);
        exp_t e;
        @(negedge aclk);
        srst     = s;
        clr      = c;
        load     = l;
        load_val = W'(lv);
        dec      = d;
        e.lr   = !c;
        e.expd = 0;
        e.und  = 0;
        if (s || c) begin
            m_out = RSTV;
            m_st  = 0;
        end else if (l) begin
            m_out = lv;
            m_st  = (lv != 0) ? 1 : 2;
        end else if (d) begin
            if (m_out == 0) begin
                e.und = 1;
`ifdef SUBTRACTOR_SATURATE_EN
                m_out = 0;
`else
                m_out = MAXV;
                if (m_st == 2) m_st = 1;
`endif
            end else begin
                if (m_out == 1 && m_st == 1) begin
                    e.expd = 1;
                    m_st   = 2;
                end
                m_out = m_out - 1;
            end
        end
        e.out  = m_out;
        e.st   = m_st;
        e.zero = (m_out == 0);
        sb_q.push_back(e);
    endtask

    // Monitor: load_ready sampled at the edge, registered outputs just after.
    initial begin
        exp_t e;
        bit   lr;
        forever begin
            @(posedge aclk);
            lr = load_ready;
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("load_ready", int'(lr), int'(e.lr));
                chk("out", int'(out), e.out);
                chk("state", int'(state), e.st);
                chk("zero", int'(zero), int'(e.zero));
                chk("expired", int'(expired), int'(e.expd));
                chk("underflow", int'(underflow), int'(e.und));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for 5 cycles.
        repeat (5) cyc(1, 0, 0, 0, 0);
        // Load 3 then count down through expiry.
        cyc(0, 0, 1, 3, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // Extra dec at zero: underflow.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        // Load with simultaneous dec, then clr with load.
        cyc(0, 0, 1, 10, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 7, 0);
        // Load of zero goes straight to EXPIRED.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Reset in the middle of a countdown.
        cyc(0, 0, 1, 8, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        // Dec from IDLE wraps/saturates without expiring.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // Randomized traffic, biased toward small loads to hit expiry often.
        for (int i = 0; i < 2000; i++) begin
            bit s, c, l, d;
            int lv;
            s  = ($urandom_range(63) == 0);
            c  = ($urandom_range(15) == 0);
            l  = ($urandom_range(3) == 0);
            d  = ($urandom_range(1) == 0);
            lv = ($urandom_range(1) == 0) ? int'($urandom_range(3)) : int'($urandom_range(MAXV));
            cyc(s, c, l, lv, d);
        end
        @(negedge aclk);
        @(negedge aclk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
